// File: rtl/complex_matrix_row_server.sv
// Row-request responder: stores a SIZE x SIZE complex matrix, streams rows on
// request with a fixed latency, and assembles inverse columns into a result store.
module complex_matrix_row_server #(
  parameter int SIZE   = 16,
  parameter int RD_LAT = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [SIZE*128-1:0]      load_row_i,
  input  logic [$clog2(SIZE)-1:0]  load_addr_i,
  input  logic                     load_valid_i,
  input  logic                     start_i,
  input  logic                     flush_i,
  input  logic [$clog2(SIZE)-1:0]  req_addr_i,
  input  logic                     req_valid_i,
  output logic [SIZE*128-1:0]      row_o,
  output logic [$clog2(SIZE)-1:0]  row_addr_o,
  output logic                     row_valid_o,
  input  logic [SIZE*128-1:0]      col_i,
  input  logic [$clog2(SIZE)-1:0]  col_addr_i,
  input  logic                     col_valid_i,
  output logic                     col_ready_o,
  input  logic [$clog2(SIZE)-1:0]  res_addr_i,
  output logic [SIZE*128-1:0]      res_row_o,
  output logic                     done_o,
  output logic                     busy_o
);

  localparam int AW = $clog2(SIZE);
  localparam int EW = 128;
  localparam int RW = SIZE * EW;

  typedef enum logic [1:0] {ST_IDLE, ST_SERVE, ST_DONE} state_t;

  state_t            state_q, state_d;
  logic [SIZE-1:0]   mask_q;
  logic [RW-1:0]     mat [SIZE];
  logic [EW-1:0]     res [SIZE][SIZE];
  logic [RD_LAT-1:0] pipe_v;
  logic [AW-1:0]     pipe_a [RD_LAT];
  logic [RW-1:0]     pipe_d [RD_LAT];
  logic              serving, col_fire, req_take;

  assign serving  = (state_q != ST_IDLE);
  assign col_fire = col_valid_i && (state_q == ST_SERVE);
  assign req_take = req_valid_i && serving && !flush_i;

  // NOTE: next-state defaults to the current state before any branch, so no
  // path leaves state_d unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (start_i) state_d = ST_SERVE;
        ST_SERVE: if (&mask_q) state_d = ST_DONE;
        ST_DONE:  if (start_i) state_d = ST_SERVE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      if (flush_i || (state_q == ST_DONE && start_i)) mask_q <= '0;
      else if (col_fire) mask_q[col_addr_i] <= 1'b1;
    end
  end

  // NOTE: matrix and result stores carry no reset; they are always written
  // before being meaningfully read, and a reset would forbid RAM mapping.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_IDLE && load_valid_i) mat[load_addr_i] <= load_row_i;
    if (col_fire) begin
      for (int r = 0; r < SIZE; r++) res[r][col_addr_i] <= col_i[r*EW +: EW];
    end
  end

  // Data stages only advance behind a valid, so row_o/row_addr_o hold through bubbles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_v <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_a[i] <= '0;
        pipe_d[i] <= '0;
      end
    end else begin
      if (flush_i) begin
        pipe_v <= '0;
      end else begin
        pipe_v[0] <= req_take;
        for (int i = 1; i < RD_LAT; i++) pipe_v[i] <= pipe_v[i-1];
      end
      if (req_take) begin
        pipe_a[0] <= req_addr_i;
        pipe_d[0] <= mat[req_addr_i];
      end
      for (int i = 1; i < RD_LAT; i++) begin
        if (pipe_v[i-1] && !flush_i) begin
          pipe_a[i] <= pipe_a[i-1];
          pipe_d[i] <= pipe_d[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_row_o <= '0;
    end else begin
      for (int c = 0; c < SIZE; c++) res_row_o[c*EW +: EW] <= res[res_addr_i][c];
    end
  end

  assign row_valid_o = pipe_v[RD_LAT-1];
  assign row_addr_o  = pipe_a[RD_LAT-1];
  assign row_o       = pipe_d[RD_LAT-1];
  assign busy_o      = (state_q != ST_IDLE);
  assign col_ready_o = (state_q == ST_SERVE);
  assign done_o      = (state_q == ST_DONE);

endmodule
